// File: rtl/arena_pkg.sv
// Arena geometry and fill-state encoding shared by the playfield modules.
package arena_pkg;

    localparam int unsigned MAP_W      = 33;
    localparam int unsigned MAP_H      = 26;
    localparam int unsigned MAP_N      = MAP_W * MAP_H;
    localparam int unsigned TILE_SIZE  = 16;
    localparam int unsigned TILE_SHIFT = 4;

    localparam int unsigned X_WALL_L = 48;
    localparam int unsigned X_WALL_R = 576;
    localparam int unsigned Y_WALL_U = 32;
    localparam int unsigned Y_WALL_D = 448;

    localparam logic [9:0] MAP_N_A   = 10'(MAP_N);
    localparam logic [9:0] LAST_ADDR = 10'(MAP_N - 1);
    localparam logic [5:0] LAST_X    = 6'(MAP_W - 1);
    localparam logic [9:0] X_LIMIT   = 10'(MAP_W * TILE_SIZE);
    localparam logic [9:0] Y_LIMIT   = 10'(MAP_H * TILE_SIZE);

    typedef enum logic {
        S_FILL,
        S_READY
    } fill_state_e;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) with synchronous seed load.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] value
);

    // An all-zero state would lock the register, so fall back to the default seed.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/block_map_module.sv
// Destructible-block map: pseudo-random fill, display/query reads and
// the bomb clear path as a two-stage read-modify-write with forwarding.
module block_map_module
    import arena_pkg::*;
#(
    parameter int unsigned DENSITY = 100,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       regen,
    input  logic [9:0] x_a,
    input  logic [9:0] y_a,
    output logic       block_on,
    input  logic [9:0] query_addr,
    output logic       query_block,
    input  logic [9:0] clr_addr,
    input  logic       clr_we,
    output logic       ready,
    output logic [9:0] blocks_left,
    output logic       map_cleared
);

    localparam logic [8:0] DENS = 9'(DENSITY);

    logic map_q [MAP_N];

    fill_state_e state_q, state_d;
    logic [9:0]  fill_addr_q, fill_addr_d;
    logic [5:0]  fill_x_q, fill_x_d;
    logic [4:0]  fill_y_q, fill_y_d;
    logic [9:0]  blocks_left_q, blocks_left_d;
    logic        ready_q, ready_d;
    logic        map_cleared_q, map_cleared_d;
    logic        block_on_q, block_on_d;
    logic        query_block_q, query_block_d;
    logic        s2_vld_q, s2_vld_d;
    logic [9:0]  s2_addr_q, s2_addr_d;
    logic        s2_old_q, s2_old_d;

    logic       wr_en;
    logic [9:0] wr_addr;
    logic       wr_data;
    logic       fill_bit;
    logic [9:0] disp_addr;
    logic [7:0] lfsr_lo;
    logic [7:0] lfsr_unused;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == S_FILL),
        .value ({lfsr_unused, lfsr_lo})
    );

    always_comb begin
        state_d       = state_q;
        fill_addr_d   = fill_addr_q;
        fill_x_d      = fill_x_q;
        fill_y_d      = fill_y_q;
        blocks_left_d = blocks_left_q;
        map_cleared_d = 1'b0;
        s2_vld_d      = 1'b0;
        s2_addr_d     = clr_addr;
        s2_old_d      = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = fill_addr_q;
        wr_data       = 1'b0;

        fill_bit = ({1'b0, lfsr_lo} < DENS)
                   && !(fill_x_q[0] && fill_y_q[0])
                   && !((fill_x_q < 6'd2) && (fill_y_q < 5'd2));

        case (state_q)
            S_FILL: begin
                if (regen) begin
                    fill_addr_d   = '0;
                    fill_x_d      = '0;
                    fill_y_d      = '0;
                    blocks_left_d = '0;
                end else begin
                    wr_en   = 1'b1;
                    wr_data = fill_bit;
                    if (fill_bit && (blocks_left_q < MAP_N_A)) begin
                        blocks_left_d = blocks_left_q + 10'd1;
                    end
                    if (fill_addr_q == LAST_ADDR) begin
                        state_d     = S_READY;
                        fill_addr_d = '0;
                        fill_x_d    = '0;
                        fill_y_d    = '0;
                    end else begin
                        fill_addr_d = fill_addr_q + 10'd1;
                        if (fill_x_q == LAST_X) begin
                            fill_x_d = '0;
                            fill_y_d = fill_y_q + 5'd1;
                        end else begin
                            fill_x_d = fill_x_q + 6'd1;
                        end
                    end
                end
            end
            S_READY: begin
                if (s2_vld_q) begin
                    wr_en   = 1'b1;
                    wr_addr = s2_addr_q;
                    if (s2_old_q && (blocks_left_q != 10'd0)) begin
                        blocks_left_d = blocks_left_q - 10'd1;
                        map_cleared_d = (blocks_left_q == 10'd1);
                    end
                end
                // A pending S2 write to the same tile means the stored bit is already stale.
                if (clr_we && (clr_addr < MAP_N_A)) begin
                    s2_vld_d = 1'b1;
                    s2_old_d = map_q[clr_addr] && !(s2_vld_q && (s2_addr_q == clr_addr));
                end
                if (regen) begin
                    state_d       = S_FILL;
                    fill_addr_d   = '0;
                    fill_x_d      = '0;
                    fill_y_d      = '0;
                    blocks_left_d = '0;
                    map_cleared_d = 1'b0;
                    s2_vld_d      = 1'b0;
                end
            end
            default: state_d = S_FILL;
        endcase

        ready_d = (state_d == S_READY);

        disp_addr  = {4'd0, x_a[9:4]} + ({4'd0, y_a[9:4]} << 5) + {4'd0, y_a[9:4]};
        block_on_d = ready_q && (x_a < X_LIMIT) && (y_a < Y_LIMIT) && map_q[disp_addr];
        query_block_d = ready_q && (query_addr < MAP_N_A) && map_q[query_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            map_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FILL;
            fill_addr_q   <= '0;
            fill_x_q      <= '0;
            fill_y_q      <= '0;
            blocks_left_q <= '0;
            ready_q       <= 1'b0;
            map_cleared_q <= 1'b0;
            block_on_q    <= 1'b0;
            query_block_q <= 1'b0;
            s2_vld_q      <= 1'b0;
            s2_addr_q     <= '0;
            s2_old_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_addr_q   <= fill_addr_d;
            fill_x_q      <= fill_x_d;
            fill_y_q      <= fill_y_d;
            blocks_left_q <= blocks_left_d;
            ready_q       <= ready_d;
            map_cleared_q <= map_cleared_d;
            block_on_q    <= block_on_d;
            query_block_q <= query_block_d;
            s2_vld_q      <= s2_vld_d;
            s2_addr_q     <= s2_addr_d;
            s2_old_q      <= s2_old_d;
        end
    end

    assign block_on    = block_on_q;
    assign query_block = query_block_q;
    assign ready       = ready_q;
    assign blocks_left = blocks_left_q;
    assign map_cleared = map_cleared_q;

endmodule

// File: tb/tb_block_map_module.sv
// Randomized bench for block_map_module against an array-based map model.
module tb_block_map_module;

    localparam int NW = 33;
    localparam int NH = 26;
    localparam int NN = NW * NH;
    localparam int DEN = 100;
    localparam int SEEDV = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       regen = 1'b0;
    logic [9:0] x_a = '0;
    logic [9:0] y_a = '0;
    logic       block_on;
    logic [9:0] query_addr = '0;
    logic       query_block;
    logic [9:0] clr_addr = '0;
    logic       clr_we = 1'b0;
    logic       ready;
    logic [9:0] blocks_left;
    logic       map_cleared;

    int checks = 0;
    int errors = 0;

    int model_map [NN];
    int first_map [NN];
    int model_cnt;
    int model_lfsr;
    int pulses;

    block_map_module #(.DENSITY(DEN), .SEED(16'hACE1)) dut (
        .clk         (clk),
        .reset       (reset),
        .regen       (regen),
        .x_a         (x_a),
        .y_a         (y_a),
        .block_on    (block_on),
        .query_addr  (query_addr),
        .query_block (query_block),
        .clr_addr    (clr_addr),
        .clr_we      (clr_we),
        .ready       (ready),
        .blocks_left (blocks_left),
        .map_cleared (map_cleared)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (map_cleared === 1'b1) pulses++;
    endtask

    function automatic int lfsr_step(input int l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l << 1) | fb) & 16'hFFFF;
    endfunction

    task automatic model_fill();
        int x, y, b;
        model_cnt = 0;
        for (int a = 0; a < NN; a++) begin
            x = a % NW;
            y = a / NW;
            b = (((model_lfsr & 255) < DEN) && !((x % 2 == 1) && (y % 2 == 1))
                 && !(x < 2 && y < 2)) ? 1 : 0;
            model_map[a] = b;
            model_cnt += b;
            model_lfsr = lfsr_step(model_lfsr);
        end
    endtask

    task automatic wait_ready(input string tag);
        int cnt = 0;
        while (ready !== 1'b1 && cnt < 2000) begin
            tick();
            cnt++;
        end
        check_eq(tag, cnt, NN);
    endtask

    task automatic dump_compare(input string tag);
        for (int a = 0; a < NN; a++) begin
            query_addr = 10'(a);
            tick();
            check_eq($sformatf("%s[%0d]", tag, a), int'(query_block), model_map[a]);
        end
    endtask

    task automatic reset_outputs(input string tag);
        check_eq({tag, "_ready"}, int'(ready), 0);
        check_eq({tag, "_blocks_left"}, int'(blocks_left), 0);
        check_eq({tag, "_block_on"}, int'(block_on), 0);
        check_eq({tag, "_query_block"}, int'(query_block), 0);
        check_eq({tag, "_map_cleared"}, int'(map_cleared), 0);
    endtask

    task automatic pixel_check(input int px, input int py);
        int exp;
        x_a = 10'(px);
        y_a = 10'(py);
        tick();
        exp = (px < 528 && py < 416) ? model_map[(px >> 4) + (py >> 4) * NW] : 0;
        check_eq($sformatf("block_on(%0d,%0d)", px, py), int'(block_on), exp);
    endtask

    task automatic find_block(input int start, output int addr);
        addr = -1;
        for (int k = 0; k < NN; k++) begin
            if (addr < 0 && model_map[(start + k) % NN] == 1) addr = (start + k) % NN;
        end
    endtask

    initial begin
        int a, prev, diff, ra;
        logic rwe;

        pulses = 0;
        model_lfsr = SEEDV;
        repeat (3) tick();
        reset_outputs("reset");
        reset = 1'b0;

        wait_ready("fill_cycles");
        model_fill();
        check_eq("blocks_left_fill1", int'(blocks_left), model_cnt);
        dump_compare("map1");
        for (int i = 0; i < NN; i++) first_map[i] = model_map[i];
        check_eq("spawn0", model_map[0] | 0, 0);

        // Spawn tiles read directly through the query port.
        foreach (first_map[i]) begin
            if (i == 0 || i == 1 || i == 33 || i == 34) begin
                query_addr = 10'(i);
                tick();
                check_eq($sformatf("spawn[%0d]", i), int'(query_block), 0);
            end
        end
        query_addr = 10'd900;
        tick();
        check_eq("query_oob", int'(query_block), 0);

        pixel_check(16 * 5 + 3, 16 * 2 + 7);
        pixel_check(530, 40);
        pixel_check(100, 420);
        for (int i = 0; i < 30; i++) pixel_check($urandom_range(0, 600), $urandom_range(0, 450));

        // Single-cycle clear with two-cycle write latency.
        find_block(40, a);
        prev = model_cnt;
        clr_addr = 10'(a);
        clr_we = 1'b1;
        tick();
        clr_we = 1'b0;
        check_eq("clr1_count_s1", int'(blocks_left), prev);
        tick();
        check_eq("clr1_count_s2", int'(blocks_left), prev - 1);
        model_map[a] = 0;
        model_cnt--;
        query_addr = 10'(a);
        tick();
        check_eq("clr1_query", int'(query_block), 0);

        // Held clear on one tile decrements once.
        find_block(200, a);
        clr_addr = 10'(a);
        clr_we = 1'b1;
        repeat (100) tick();
        clr_we = 1'b0;
        repeat (3) tick();
        model_map[a] = 0;
        model_cnt--;
        check_eq("held_clear_count", int'(blocks_left), model_cnt);

        clr_we = 1'b1;
        clr_addr = 10'd900;
        repeat (5) tick();
        clr_addr = 10'd1023;
        repeat (5) tick();
        clr_we = 1'b0;
        repeat (3) tick();
        check_eq("oob_clear_count", int'(blocks_left), model_cnt);

        // Random clear traffic, including repeats and out-of-range addresses.
        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, NN - 1);
            if ($urandom_range(0, 3) == 0 && i > 0) ra = int'(clr_addr);
            rwe = 1'($urandom_range(0, 1));
            clr_addr = 10'(ra);
            clr_we = rwe;
            if (rwe && ra < NN && model_map[ra] == 1) begin
                model_map[ra] = 0;
                model_cnt--;
            end
            tick();
        end
        clr_we = 1'b0;
        repeat (3) tick();
        check_eq("rand_clear_count", int'(blocks_left), model_cnt);
        dump_compare("map_rand");
        check_eq("no_pulse_yet", pulses, 0);

        // Regenerate after partial clears; LFSR continues from where fill stopped.
        regen = 1'b1;
        tick();
        regen = 1'b0;
        check_eq("regen_ready_drop", int'(ready), 0);
        check_eq("regen_count_zero", int'(blocks_left), 0);
        wait_ready("refill_cycles");
        model_fill();
        check_eq("blocks_left_fill2", int'(blocks_left), model_cnt);
        dump_compare("map2");
        diff = 0;
        for (int i = 0; i < NN; i++) if (model_map[i] != first_map[i]) diff++;
        check_eq("map2_differs", int'(diff > 0), 1);

        // Clear every block back-to-back.
        pulses = 0;
        for (int i = 0; i < NN; i++) begin
            if (model_map[i] == 1) begin
                clr_addr = 10'(i);
                clr_we = 1'b1;
                tick();
            end
        end
        clr_we = 1'b0;
        repeat (5) tick();
        check_eq("all_clear_count", int'(blocks_left), 0);
        check_eq("map_cleared_pulses", pulses, 1);

        // Reset in the middle of a refill.
        regen = 1'b1;
        tick();
        regen = 1'b0;
        repeat (300) tick();
        reset = 1'b1;
        query_addr = 10'd40;
        x_a = 10'd83;
        y_a = 10'd39;
        repeat (2) tick();
        reset_outputs("midfill_reset");
        reset = 1'b0;
        model_lfsr = SEEDV;
        wait_ready("fill_after_reset");
        model_fill();
        check_eq("blocks_left_fill3", int'(blocks_left), model_cnt);
        diff = 0;
        for (int i = 0; i < NN; i++) if (model_map[i] != first_map[i]) diff++;
        check_eq("reseed_repeats_map1", diff, 0);
        dump_compare("map3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
